// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces two active-low keys and a 4-bit rotary code.
// Define KEY_COND_LONGPRESS_EN to add the key2 long-press pulse on o_key2_long.
module key_conditioner #(
    parameter int DB_CYCLES   = 100000,
    parameter int LONG_CYCLES = 10000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key1_n,
    input  logic       i_key2_n,
    input  logic [3:0] i_rotary,
    output logic       o_key1_level,
    output logic       o_key2_level,
    output logic       o_key1_pulse,
    output logic       o_key2_pulse,
    output logic [3:0] o_rotary,
    output logic       o_rotary_chg,
    output logic       o_key2_long
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DB_FIRE = CW'(DB_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} state_t;

    logic [1:0] key_meta, key_sync;
    logic [3:0] rot_meta, rot_sync;
    logic [3:0] cand;
    logic [CW-1:0] rcnt;

    // two-flop synchronizers; keys idle high, rotary idles at zero
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            key_meta <= '1;
            key_sync <= '1;
            rot_meta <= '0;
            rot_sync <= '0;
        end else begin
            key_meta <= {i_key2_n, i_key1_n};
            key_sync <= key_meta;
            rot_meta <= i_rotary;
            rot_sync <= rot_meta;
        end

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_key
            state_t st;
            logic [CW-1:0] cnt;
            logic level, pulse;
            // debounce FSM; the sample that leaves a stable state already counts as the first one
            always_ff @(posedge i_clk or posedge i_rst)
                if (i_rst) begin
                    st    <= IDLE;
                    cnt   <= '0;
                    level <= 1'b1;
                    pulse <= 1'b0;
                end else begin
                    pulse <= 1'b0;
                    case (st)
                        IDLE:
                            if (!key_sync[k]) begin
                                st  <= PRESS_WAIT;
                                cnt <= CW'(1);
                            end
                        PRESS_WAIT:
                            if (key_sync[k]) begin
                                st  <= IDLE;
                                cnt <= '0;
                            end else if (cnt == DB_LAST) begin
                                st    <= PRESSED;
                                cnt   <= '0;
                                level <= 1'b0;
                                pulse <= 1'b1;
                            end else if (cnt != DB_MAX) cnt <= cnt + 1'b1;
                        PRESSED:
                            if (key_sync[k]) begin
                                st  <= REL_WAIT;
                                cnt <= CW'(1);
                            end
                        REL_WAIT:
                            if (!key_sync[k]) begin
                                st  <= PRESSED;
                                cnt <= '0;
                            end else if (cnt == DB_LAST) begin
                                st    <= IDLE;
                                cnt   <= '0;
                                level <= 1'b1;
                            end else if (cnt != DB_MAX) cnt <= cnt + 1'b1;
                        default: st <= IDLE;
                    endcase
                end
        end
    endgenerate

    assign o_key1_level = g_key[0].level;
    assign o_key2_level = g_key[1].level;
    assign o_key1_pulse = g_key[0].pulse;
    assign o_key2_pulse = g_key[1].pulse;

    // candidate must match for DB_CYCLES consecutive samples before it may replace the output;
    // rcnt counts matches after the first, so the load lands in step with the key pulses
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            cand         <= '0;
            rcnt         <= '0;
            o_rotary     <= '0;
            o_rotary_chg <= 1'b0;
        end else begin
            o_rotary_chg <= 1'b0;
            if (rot_sync != cand) begin
                cand <= rot_sync;
                rcnt <= '0;
            end else begin
                if (rcnt != DB_MAX) rcnt <= rcnt + 1'b1;
                if (rcnt == DB_FIRE && cand != o_rotary) begin
                    o_rotary     <= cand;
                    o_rotary_chg <= 1'b1;
                end
            end
        end

`ifdef KEY_COND_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] lcnt;
    // key2 hold timer, cleared whenever key2 is not in the settled pressed state
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            lcnt        <= '0;
            o_key2_long <= 1'b0;
        end else begin
            o_key2_long <= g_key[1].st == PRESSED && lcnt == LW'(LONG_CYCLES - 1);
            lcnt        <= g_key[1].st != PRESSED ? '0 : lcnt == LW'(LONG_CYCLES) ? lcnt : lcnt + 1'b1;
        end
`else
    assign o_key2_long = 1'b0;
`endif
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random stimulus against a run-length reference model of key_conditioner
module tb_key_conditioner;
    localparam int DB = 8, LONG = 40;

    logic clk = 1'b0, rst = 1'b1, key1_n = 1'b1, key2_n = 1'b1;
    logic [3:0] rotary = '0;
    logic key1_level, key2_level, key1_pulse, key2_pulse, rotary_chg, key2_long;
    logic [3:0] rotary_q;
    int n_tests = 0, n_fail = 0;

    logic [1:0] m_s1, m_s2, m_lvl, m_pls;
    int m_run [2];
    logic [3:0] m_r1, m_r2, m_rprev, m_rout;
    int m_rrun, m_held;
    logic m_chg, m_long;
    int c_p1, c_p2, c_chg, c_long;
    logic saw7;

    always #5 clk = ~clk;

    key_conditioner #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .i_clk(clk), .i_rst(rst), .i_key1_n(key1_n), .i_key2_n(key2_n), .i_rotary(rotary),
        .o_key1_level(key1_level), .o_key2_level(key2_level),
        .o_key1_pulse(key1_pulse), .o_key2_pulse(key2_pulse),
        .o_rotary(rotary_q), .o_rotary_chg(rotary_chg), .o_key2_long(key2_long)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_lvl = '1; m_pls = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_r1 = '0; m_r2 = '0; m_rprev = '0; m_rout = '0;
        m_rrun = 0; m_held = 0; m_chg = 1'b0; m_long = 1'b0;
    endtask

    // a level flips once DB consecutive synchronized samples disagree with it
    task automatic model_clock();
        logic [1:0] s;
        logic [3:0] rs;
        s = m_s2; m_s2 = m_s1; m_s1 = {key2_n, key1_n};
        rs = m_r2; m_r2 = m_r1; m_r1 = rotary;
        m_long = 1'b0;
        if (!m_lvl[1] && m_run[1] == 0) begin
            m_held++;
            m_long = (m_held == LONG);
        end else m_held = 0;
        m_pls = '0;
        for (int i = 0; i < 2; i++)
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    m_pls[i] = ~s[i];
                end
            end else m_run[i] = 0;
        m_chg = 1'b0;
        if (rs != m_rprev) begin
            m_rprev = rs;
            m_rrun = 1;
        end else m_rrun++;
        if (m_rrun == DB && rs != m_rout) begin
            m_rout = rs;
            m_chg = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_clock();
        @(negedge clk);
        check("key1_level", 32'(key1_level), 32'(m_lvl[0]));
        check("key2_level", 32'(key2_level), 32'(m_lvl[1]));
        check("key1_pulse", 32'(key1_pulse), 32'(m_pls[0]));
        check("key2_pulse", 32'(key2_pulse), 32'(m_pls[1]));
        check("rotary", 32'(rotary_q), 32'(m_rout));
        check("rotary_chg", 32'(rotary_chg), 32'(m_chg));
`ifdef KEY_COND_LONGPRESS_EN
        check("key2_long", 32'(key2_long), 32'(m_long));
`else
        check("key2_long", 32'(key2_long), 32'h0);
`endif
        c_p1 += int'(key1_pulse);
        c_p2 += int'(key2_pulse);
        c_chg += int'(rotary_chg);
        c_long += int'(key2_long);
        saw7 |= (rotary_q == 4'h7);
    endtask

    task automatic clear_counts();
        c_p1 = 0; c_p2 = 0; c_chg = 0; c_long = 0; saw7 = 1'b0;
    endtask

    task automatic wait_key_pulse(input int k, output int lat);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step();
            if ((k == 0 ? key1_pulse : key2_pulse) === 1'b1) lat = i;
        end
    endtask

    initial begin
        int lat, t_p, t_l, len1, len2, lenr;
        model_reset();
        clear_counts();
        repeat (3) step();
        check("reset_rotary", 32'(rotary_q), 32'h0);
        check("reset_level1", 32'(key1_level), 32'h1);
        rst = 1'b0;
        repeat (3) step();

        clear_counts();
        key1_n = 1'b0;
        wait_key_pulse(0, lat);
        check("k1_press_latency_ok", 32'(lat >= 10 && lat <= 11), 32'h1);
        repeat (50 - lat) step();
        key1_n = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step();
            if (key1_level === 1'b1) lat = i;
        end
        check("k1_release_latency_ok", 32'(lat >= 10 && lat <= 11), 32'h1);
        repeat (5) step();
        check("k1_pulse_count", 32'(c_p1), 32'h1);

        clear_counts();
        for (int i = 0; i < 30; i++) begin
            key2_n = 1'((i / 3) % 2);
            step();
        end
        check("k2_bounce_pulses", 32'(c_p2), 32'h0);
        key2_n = 1'b0;
        wait_key_pulse(1, lat);
        check("k2_hold_latency_ok", 32'(lat >= 10 && lat <= 11), 32'h1);
        repeat (5) step();
        check("k2_pulse_count", 32'(c_p2), 32'h1);
        key2_n = 1'b1;
        repeat (15) step();

        clear_counts();
        rotary = 4'h7;
        repeat (4) step();
        rotary = 4'h5;
        repeat (20) step();
        check("rot_value", 32'(rotary_q), 32'h5);
        check("rot_chg_count", 32'(c_chg), 32'h1);
        check("rot_never_7", 32'(saw7), 32'h0);

        clear_counts();
        key1_n = 1'b0; key2_n = 1'b0; rotary = 4'h9;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step();
            if (key1_pulse || key2_pulse || rotary_chg) lat = i;
        end
        check("sim_key1_pulse", 32'(key1_pulse), 32'h1);
        check("sim_key2_pulse", 32'(key2_pulse), 32'h1);
        check("sim_rotary_chg", 32'(rotary_chg), 32'h1);
        key1_n = 1'b1; key2_n = 1'b1;
        repeat (15) step();

        clear_counts();
        key1_n = 1'b0;
        repeat (7) step();
        check("k1_pre_reset_pulses", 32'(c_p1), 32'h0);
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        wait_key_pulse(0, lat);
        check("k1_post_reset_latency_ok", 32'(lat >= 10 && lat <= 11), 32'h1);
        check("k1_post_reset_pulses", 32'(c_p1), 32'h1);
        key1_n = 1'b1;
        repeat (15) step();

        clear_counts();
        key2_n = 1'b0;
        t_p = -1; t_l = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (key2_pulse) t_p = i;
            if (key2_long) t_l = i;
        end
        key2_n = 1'b1;
        repeat (15) step();
        check("k2_hold_pulse_count", 32'(c_p2), 32'h1);
`ifdef KEY_COND_LONGPRESS_EN
        check("k2_long_count", 32'(c_long), 32'h1);
        check("k2_long_gap", 32'(t_l - t_p), 32'(LONG));
`else
        check("k2_long_count", 32'(c_long), 32'h0);
`endif

        len1 = 0; len2 = 0; lenr = 0;
        for (int i = 0; i < 4000; i++) begin
            if (len1 == 0) begin key1_n = 1'($urandom_range(0, 1)); len1 = $urandom_range(1, 60); end
            if (len2 == 0) begin key2_n = 1'($urandom_range(0, 1)); len2 = $urandom_range(1, 60); end
            if (lenr == 0) begin rotary = 4'($urandom_range(0, 15)); lenr = $urandom_range(1, 24); end
            len1--; len2--; lenr--;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 100000, stable-time qualifier in clocks (10 ms at 10 MHz).
REQ-002 Parameter LONG_CYCLES, default 10000000, key2 hold time for long-press detect (1 s at 10 MHz).
REQ-003 i_clk  input  1  system clock, 10 MHz; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_key1_n  input  1  raw mode key, active-low, asynchronous to i_clk.
REQ-006 i_key2_n  input  1  raw clear key, active-low, asynchronous to i_clk.
REQ-007 i_rotary  input  4  raw rotary switch code, asynchronous to i_clk.
REQ-008 o_key1_level, o_key2_level  output  1 each  debounced key state, active-low, so idle reads 1.
REQ-009 o_key1_pulse, o_key2_pulse  output  1 each  one-cycle active-high pulse per qualified press.
REQ-010 o_rotary  output  4  debounced rotary code.
REQ-011 o_rotary_chg  output  1  one-cycle pulse when o_rotary takes a new value.
REQ-012 o_key2_long  output  1  one-cycle pulse on key2 long press; present only per REQ-026.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other logic uses it.
REQ-014 Each key SHALL use a 4-state FSM: IDLE, PRESS_WAIT, PRESSED, REL_WAIT.
REQ-015 IDLE->PRESS_WAIT on synchronized key = 0; PRESS_WAIT->IDLE on key = 1 before count completes, with the counter cleared.
REQ-016 PRESS_WAIT->PRESSED after key = 0 for DB_CYCLES consecutive clocks; o_keyN_level goes to 0 and o_keyN_pulse is 1 for exactly that cycle.
REQ-017 PRESSED->REL_WAIT on key = 1; REL_WAIT->PRESSED on key = 0 before count completes; REL_WAIT->IDLE after DB_CYCLES consecutive 1s, at which point o_keyN_level returns to 1 and no pulse is produced.
REQ-018 Press latency from the raw falling edge to the pulse SHALL be DB_CYCLES+2 to DB_CYCLES+3 clocks; bounce SHALL restart the count.
REQ-019 Debounce counters SHALL be sized ceil(log2(DB_CYCLES+1)) bits and SHALL saturate, never wrap.
REQ-020 Rotary: a candidate register holds the synchronized code, and its counter clears whenever the code differs from the candidate.
REQ-021 When the candidate is stable for DB_CYCLES clocks and differs from o_rotary, o_rotary SHALL load it and o_rotary_chg SHALL pulse for 1 cycle; a stable code equal to o_rotary produces no pulse.
REQ-022 Keys and rotary SHALL be fully independent; simultaneous events each produce their own pulse in the same cycle.
REQ-023 A key held indefinitely SHALL produce exactly one pulse.

Reset
REQ-024 While i_rst = 1, the following SHALL hold asynchronously: synchronizers = 1 for keys and 0 for rotary, FSMs = IDLE, counters = 0, o_keyN_level = 1, all pulses = 0, o_rotary = 4'h0.
REQ-025 Reset asserted mid-debounce SHALL discard the count; a key held through reset release requires a full DB_CYCLES qualification before it pulses.

Configuration
REQ-026 Macro KEY_COND_LONGPRESS_EN: when defined, a counter runs in key2 PRESSED and o_key2_long pulses once when the hold reaches LONG_CYCLES; the counter clears on leaving PRESSED. When undefined, o_key2_long is tied to 0 and no long-press counter is synthesized.

Verification (DB_CYCLES=8, LONG_CYCLES=40)
REQ-027 Clean key1 press held 50 clocks -> one o_key1_pulse at clock 10-11 after the edge, o_key1_level = 0 until 10-11 clocks after release.
REQ-028 Key2 bounce 0/1 toggling every 3 clocks for 30 clocks, then held 0 -> no pulse during bounce, exactly one pulse 10-11 clocks after the final hold begins.
REQ-029 Rotary 0->5 with a 4-clock glitch to 7 first -> o_rotary never shows 7, o_rotary = 5 with one o_rotary_chg pulse.
REQ-030 Key1, key2 and the rotary change released on the same clock -> all three pulses appear in the same cycle.
REQ-031 i_rst pulsed during PRESS_WAIT at count 5 -> no pulse; after reset release a further 8-clock hold gives a pulse.
REQ-032 With KEY_COND_LONGPRESS_EN, key2 held 60 clocks -> one o_key2_pulse and one o_key2_long, 40 clocks apart; without the macro, o_key2_long stays 0.
